// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer: the sequencer state
// encoding and the counter-width helpers used to size its counters.
package reset_seq_pkg;

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      LOCK_FILT = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4,
      SW_RST    = 3'd5
   } seq_state_t;

   // Width of a saturating counter able to hold max_count.
   function automatic int cnt_width(input int max_count);
      return $clog2(max_count) + 1;
   endfunction

   // Largest of three values; sizes the counter shared between states.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous level inputs.
// Both flops clear to 0 while reset_in_n is low.
module sync_2ff (
   input  logic clk_in,
   input  logic reset_in_n,
   input  logic d,
   output logic q
);

   logic meta_reg;
   logic sync_reg;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk_in or negedge reset_in_n) begin
      if (!reset_in_n) begin
         meta_reg <= 1'b0;
         sync_reg <= 1'b0;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/reset_sequencer.sv
// Power-up / recovery reset sequencer. Pulses the clock wizard reset,
// filters its lock indication, then releases NUM_DOMAINS active-low resets
// in ascending order. Lock loss or a software request re-asserts them all.
// Optional lock watchdog compiled in with RESET_SEQ_WATCHDOG_EN.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_DOMAINS        = 4,
   parameter int PLL_RST_CYCLES     = 16,
   parameter int LOCK_FILTER_CYCLES = 64,
   parameter int GAP_CYCLES         = 8,
   parameter int TIMEOUT_CYCLES     = 65536
) (
   input  logic                   clk_in,
   input  logic                   reset_in_n,
   input  logic                   locked,
   output logic                   pll_reset,
   output logic [NUM_DOMAINS-1:0] rst_out_n,
   output logic                   ready,
   input  logic                   sw_rst_req,
   output logic                   sw_rst_ack,
   output logic                   lock_timeout
);

   // One counter serves the PLL pulse, the lock filter and the release gaps.
   localparam int CNT_MAX = max3(PLL_RST_CYCLES, LOCK_FILTER_CYCLES, GAP_CYCLES);
   localparam int CNT_W   = cnt_width(CNT_MAX);
   localparam int IDX_W   = cnt_width(NUM_DOMAINS);

   localparam logic [CNT_W-1:0] PLL_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILTER_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

   logic lock_s;
   logic req_s;

   seq_state_t state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
   logic [IDX_W-1:0] idx_reg, idx_next;
   logic release_fire;
   logic timeout_fire;

   logic                   pll_reset_reg, pll_reset_next;
   logic [NUM_DOMAINS-1:0] rst_n_reg, rst_n_next;
   logic                   ready_reg, ready_next;
   logic                   ack_reg, ack_next;
   logic                   clear_all;

   sync_2ff u_sync_lock (
      .clk_in     (clk_in),
      .reset_in_n (reset_in_n),
      .d          (locked),
      .q          (lock_s)
   );

   sync_2ff u_sync_req (
      .clk_in     (clk_in),
      .reset_in_n (reset_in_n),
      .d          (sw_rst_req),
      .q          (req_s)
   );

   assign cnt_inc = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + CNT_W'(1);

`ifdef RESET_SEQ_WATCHDOG_EN
   localparam int WD_W = cnt_width(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [WD_W-1:0] WD_SAT  = WD_W'(TIMEOUT_CYCLES);

   logic [WD_W-1:0] wd_reg, wd_next;
   logic            lt_reg;

   // Watchdog counts every cycle spent waiting for (or filtering) lock.
   always_comb begin
      wd_next      = '0;
      timeout_fire = 1'b0;
      if (state_reg == WAIT_LOCK || state_reg == LOCK_FILT) begin
         timeout_fire = (wd_reg == WD_LAST);
         wd_next      = (wd_reg == WD_SAT) ? wd_reg : wd_reg + WD_W'(1);
      end
   end

   // Watchdog counter and sticky timeout flag.
   always_ff @(posedge clk_in or negedge reset_in_n) begin
      if (!reset_in_n) begin
         wd_reg <= '0;
         lt_reg <= 1'b0;
      end else begin
         wd_reg <= wd_next;
         lt_reg <= lt_reg | timeout_fire;
      end
   end

   assign lock_timeout = lt_reg;
`else
   assign timeout_fire = 1'b0;
   // Never true: the flag is tied low when no watchdog is built.
   assign lock_timeout = (TIMEOUT_CYCLES < 0);
`endif

   // State register plus the registered outputs.
   always_ff @(posedge clk_in or negedge reset_in_n) begin
      if (!reset_in_n) begin
         state_reg     <= PLL_RST;
         cnt_reg       <= '0;
         idx_reg       <= '0;
         pll_reset_reg <= 1'b1;
         rst_n_reg     <= '0;
         ready_reg     <= 1'b0;
         ack_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         idx_reg       <= idx_next;
         pll_reset_reg <= pll_reset_next;
         rst_n_reg     <= rst_n_next;
         ready_reg     <= ready_next;
         ack_reg       <= ack_next;
      end
   end

   // Next-state logic; lock loss outranks a pending software request.
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      idx_next     = idx_reg;
      release_fire = 1'b0;
      case (state_reg)
         PLL_RST: begin
            if (cnt_reg == PLL_LAST) state_next = WAIT_LOCK;
            else                     cnt_next   = cnt_inc;
         end
         WAIT_LOCK: begin
            if (lock_s) state_next = LOCK_FILT;
         end
         LOCK_FILT: begin
            if (!lock_s)                 state_next = WAIT_LOCK;
            else if (cnt_reg == FILT_LAST) state_next = RELEASE;
            else                         cnt_next   = cnt_inc;
         end
         RELEASE: begin
            if (!lock_s) begin
               state_next = WAIT_LOCK;
            end else if (cnt_reg == GAP_LAST) begin
               release_fire = 1'b1;
               cnt_next     = '0;
               if (idx_reg == IDX_LAST) state_next = RUN;
               else                     idx_next   = idx_reg + IDX_W'(1);
            end else begin
               cnt_next = cnt_inc;
            end
         end
         RUN: begin
            if (!lock_s)    state_next = WAIT_LOCK;
            else if (req_s) state_next = SW_RST;
         end
         SW_RST: begin
            // Hold for the gap time, then wait for the request to drop.
            if (!lock_s) begin
               state_next = WAIT_LOCK;
            end else if (cnt_reg == GAP_LAST) begin
               if (!req_s) state_next = RELEASE;
            end else begin
               cnt_next = cnt_inc;
            end
         end
         default: state_next = PLL_RST;
      endcase

      if (timeout_fire) state_next = PLL_RST;

      // Every state starts its own count from zero.
      if (state_next != state_reg) cnt_next = '0;
      if (state_next != RELEASE)   idx_next = '0;
   end

   // Output decode from the next state so outputs align with the state register.
   always_comb begin
      pll_reset_next = (state_next == PLL_RST);
      ready_next     = (state_next == RUN);
      ack_next       = (state_next == SW_RST);
      clear_all      = !(state_next == RELEASE || state_next == RUN);
   end

   // Per-domain reset: cleared together, set one at a time in index order.
   generate
      for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_dom
         assign rst_n_next[gi] = clear_all ? 1'b0 :
                                 ((release_fire && idx_reg == IDX_W'(gi)) ? 1'b1 : rst_n_reg[gi]);
      end
   endgenerate

   assign pll_reset  = pll_reset_reg;
   assign rst_out_n  = rst_n_reg;
   assign ready      = ready_reg;
   assign sw_rst_ack = ack_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer. Every output change is matched against a
// scoreboard of (cycle, value) events queued when the stimulus is applied.
// Event value layout: {lock_timeout, sw_rst_ack, ready, pll_reset, rst_out_n[3:0]}.
module tb_reset_sequencer;

   localparam int ND     = 4;
   localparam int FILT_C = 64;
   localparam int GAP_C  = 8;
   localparam int TO_C   = 200;

   logic          clk_in     = 1'b0;
   logic          reset_in_n = 1'b1;
   logic          locked     = 1'b0;
   logic          sw_rst_req = 1'b0;
   logic          pll_reset;
   logic [ND-1:0] rst_out_n;
   logic          ready;
   logic          sw_rst_ack;
   logic          lock_timeout;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int run_at = 0;

   typedef struct {
      int at;
      int val;
   } ev_t;

   ev_t        sb_q[$];
   logic       mon_en   = 1'b0;
   logic [7:0] prev_val = 8'h00;
   logic       lt_exp   = 1'b0;

   wire [7:0] out_vec = {lock_timeout, sw_rst_ack, ready, pll_reset, rst_out_n};

   reset_sequencer #(
      .NUM_DOMAINS        (ND),
      .PLL_RST_CYCLES     (16),
      .LOCK_FILTER_CYCLES (FILT_C),
      .GAP_CYCLES         (GAP_C),
      .TIMEOUT_CYCLES     (TO_C)
   ) dut (
      .clk_in       (clk_in),
      .reset_in_n   (reset_in_n),
      .locked       (locked),
      .pll_reset    (pll_reset),
      .rst_out_n    (rst_out_n),
      .ready        (ready),
      .sw_rst_req   (sw_rst_req),
      .sw_rst_ack   (sw_rst_ack),
      .lock_timeout (lock_timeout)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic push(input int at, input logic [7:0] v);
      ev_t e;
      e.at  = at;
      e.val = int'(v);
      sb_q.push_back(e);
   endtask

   // Ordered release starting at RELEASE entry cycle rel.
   task automatic push_release(input int rel);
      logic [7:0] v;
      v = {lt_exp, 7'b0};
      for (int k = 0; k < ND; k++) begin
         v[k] = 1'b1;
         if (k == ND - 1) v[5] = 1'b1;
         push(rel + GAP_C * (k + 1), v);
      end
      run_at = rel + GAP_C * ND;
   endtask

   // Inputs change 1 time unit after the given clock edge.
   task automatic step_to(input int n);
      while (cyc < n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   // Scoreboard monitor: sample away from the active edge.
   always @(negedge clk_in) begin
      if (mon_en && out_vec !== prev_val) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_change", out_vec, prev_val);
         end else begin
            ev_t e;
            e = sb_q.pop_front();
            $display("EV cycle=%0d value=0x%02h expected_cycle=%0d expected_value=0x%02h",
                     cyc, out_vec, e.at, e.val);
            chk("ev_cycle", cyc, e.at);
            chk("ev_value", out_vec, e.val);
         end
         prev_val = out_vec;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=%0d expected<200000", $time);
      $fatal(1, "time limit");
   end

   initial begin
      int t, w, l, a, rel, r;
      #1 reset_in_n = 1'b0;
      step_to(3);
      chk("rst_pll_reset", pll_reset, 1);
      chk("rst_domains", rst_out_n, 0);
      chk("rst_ready", ready, 0);
      chk("rst_ack", sw_rst_ack, 0);
      chk("rst_lock_timeout", lock_timeout, 0);
      prev_val = out_vec;
      mon_en   = 1'b1;

      // Power-up: 16-cycle PLL pulse, lock at cycle 30 after release.
      step_to(5);
      reset_in_n = 1'b1;
      push(5 + 16, 8'h00);
      step_to(35);
      locked = 1'b1;
      push_release(35 + 3 + FILT_C);

      // Lock loss in RUN, then re-lock.
      t = run_at + 6;
      step_to(t);
      locked = 1'b0;
      push(t + 3, 8'h00);
      step_to(t + 5);
      chk("loss_no_pll_pulse", pll_reset, 0);
      chk("loss_ready_low", ready, 0);
      step_to(t + 10);
      locked = 1'b1;
      push_release(t + 13 + FILT_C);

      // One-cycle glitch midway through the lock filter.
      t = run_at + 6;
      step_to(t);
      locked = 1'b0;
      push(t + 3, 8'h00);
      step_to(t + 10);
      locked = 1'b1;
      l = t + 13;
      step_to(l + 32);
      locked = 1'b0;
      step_to(l + 33);
      locked = 1'b1;
      push_release(l + 36 + FILT_C);

      // Software reset with a long request.
      t = run_at + 6;
      step_to(t);
      sw_rst_req = 1'b1;
      push(t + 3, 8'h40);
      step_to(t + 20);
      sw_rst_req = 1'b0;
      push(t + 23, 8'h00);
      push_release(t + 23);

      // Software reset with a short request: hold time sets the exit.
      t = run_at + 6;
      step_to(t);
      sw_rst_req = 1'b1;
      push(t + 3, 8'h40);
      step_to(t + 4);
      sw_rst_req = 1'b0;
      push(t + 11, 8'h00);
      push_release(t + 11);

      // Simultaneous lock loss and request: lock wins, request served later.
      t = run_at + 6;
      step_to(t);
      locked     = 1'b0;
      sw_rst_req = 1'b1;
      push(t + 3, 8'h00);
      step_to(t + 10);
      locked = 1'b1;
      push_release(t + 13 + FILT_C);
      a = run_at;
      push(a + 1, 8'h40);
      step_to(a + 14);
      sw_rst_req = 1'b0;
      push(a + 17, 8'h00);
      push_release(a + 17);

      // Lock never returns: watchdog behaviour.
      t = run_at + 6;
      step_to(t);
      locked = 1'b0;
      push(t + 3, 8'h00);
      w = t + 3;
`ifdef RESET_SEQ_WATCHDOG_EN
      push(w + TO_C, 8'h90);
      push(w + TO_C + 16, 8'h80);
      push(w + 2 * (TO_C + 16) - 16, 8'h90);
      push(w + 2 * (TO_C + 16), 8'h80);
      lt_exp = 1'b1;
`endif
      step_to(w + 440);
      chk("wd_lock_timeout", lock_timeout, lt_exp);
      chk("wd_pll_idle", pll_reset, 0);

      // Asynchronous reset after two domains are released.
      t = w + 440;
      locked = 1'b1;
      rel = t + 3 + FILT_C;
      push(rel + GAP_C, {lt_exp, 7'h01});
      push(rel + 2 * GAP_C, {lt_exp, 7'h03});
      step_to(rel + 2 * GAP_C + 2);
      chk("pre_areset_domains", rst_out_n, 4'b0011);
      reset_in_n = 1'b0;
      push(rel + 2 * GAP_C + 2, 8'h10);
      #1;
      chk("areset_pll_reset", pll_reset, 1);
      chk("areset_domains", rst_out_n, 0);
      chk("areset_ready", ready, 0);
      chk("areset_lock_timeout", lock_timeout, 0);
      lt_exp = 1'b0;
      r = rel + 2 * GAP_C + 6;
      step_to(r);
      reset_in_n = 1'b1;
      push(r + 16, 8'h00);
      push_release(r + 17 + FILT_C);

      step_to(run_at + 5);
      chk("ready_final", ready, 1);
      chk("sb_empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
